bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one sequential binary-to-BCD converter among NUM_CH requesters. It arbitrates requests and launches one conversion at a time on the converter's `en`/`bin_in` port. It waits for the converter's one-cycle `ready` pulse, then returns the 16-bit BCD result to the granted requester with a tagged done pulse. It sits between display/telemetry producers and the single converter instance.

---
 rtl/bcd_conv_sched.sv | 165 ++++++++++++++++
 tb/tb_bcd_conv_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one sequential binary-to-BCD converter among NUM_CH requesters.
// One conversion in flight at a time; results come back tagged with the channel that asked.
module bcd_conv_sched #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 40,
    parameter int FLUSH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH*12-1:0] bin_flat,
    output logic                 done,
    output logic [CH_W-1:0]      done_ch,
    output logic [15:0]          bcd_res,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 conv_en,
    output logic [11:0]          conv_bin,
    input  logic [15:0]          conv_bcd,
    input  logic                 conv_ready,
    output logic [2:0]           dbg_state
);
    // Handshake: req[k] is a level held (with a stable operand) until a done pulse tags channel k;
    // done is a single-cycle pulse and done_ch/bcd_res/timeout_err hold until the next one.
    localparam int FC_W = (FLUSH > 2) ? $clog2(FLUSH) : 1;
    localparam int TC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH - 1);
    localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [TC_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] done_ch_q, done_ch_d;
    logic            conv_en_q, conv_en_d;
    logic [11:0]     conv_bin_q, conv_bin_d;
    logic [15:0]     bcd_res_q, bcd_res_d;
    logic            timeout_err_q, timeout_err_d;

    logic [2*NUM_CH-1:0] req_rot;
    logic                gnt_found;
    logic [CH_W-1:0]     gnt_idx;
    logic [11:0]         gnt_bin;
    int                  gnt_pos;

    // Rotating the doubled request vector puts the pointer's channel at bit 0.
    always_comb begin
        req_rot   = {req, req} >> ptr_q;
        gnt_found = 1'b0;
        gnt_pos   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && req_rot[i]) begin
                gnt_found = 1'b1;
                gnt_pos   = int'(ptr_q) + i;
            end
        end
        if (gnt_pos >= NUM_CH) begin
            gnt_pos = gnt_pos - NUM_CH;
        end
        gnt_idx = CH_W'(gnt_pos);
        gnt_bin = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                gnt_bin = bin_flat[i*12 +: 12];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        done_ch_d     = done_ch_q;
        conv_en_d     = conv_en_q;
        conv_bin_d    = conv_bin_q;
        bcd_res_d     = bcd_res_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            S_FLUSH: begin
                // The converter has no reset; let any stale run drain before trusting conv_ready.
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (gnt_found) begin
                    grant_d       = gnt_idx;
                    conv_bin_d    = gnt_bin;
                    conv_en_d     = 1'b1;
                    timeout_err_d = 1'b0;
                    state_d       = S_START;
                end
            end
            S_START: begin
                conv_en_d = 1'b0;
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (conv_ready) begin
                    bcd_res_d     = conv_bcd;
                    timeout_err_d = 1'b0;
                    done_ch_d     = grant_q;
                    state_d       = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    bcd_res_d     = '0;
                    timeout_err_d = 1'b1;
                    done_ch_d     = grant_q;
                    state_d       = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                ptr_d   = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FLUSH;
            flush_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            ptr_q         <= '0;
            grant_q       <= '0;
            done_ch_q     <= '0;
            conv_en_q     <= 1'b0;
            conv_bin_q    <= '0;
            bcd_res_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            done_ch_q     <= done_ch_d;
            conv_en_q     <= conv_en_d;
            conv_bin_q    <= conv_bin_d;
            bcd_res_q     <= bcd_res_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign done        = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign done_ch     = done_ch_q;
    assign bcd_res     = bcd_res_q;
    assign timeout_err = timeout_err_q;
    assign conv_en     = conv_en_q;
    assign conv_bin    = conv_bin_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: behavioural converter, round-robin reference model with an
// expected-result queue, a vector table, directed corner sequences and random traffic.
module tb_bcd_conv_sched;
    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int TIMEOUT  = 40;
    localparam int FLUSH    = 32;
    localparam int CONV_LAT = 26;
    localparam int EW       = CH_W + 17;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH*12-1:0] bin_flat;
    logic                 done;
    logic [CH_W-1:0]      done_ch;
    logic [15:0]          bcd_res;
    logic                 timeout_err;
    logic                 busy;
    logic                 conv_en;
    logic [11:0]          conv_bin;
    logic [15:0]          conv_bcd = '0;
    logic                 conv_ready;
    logic [2:0]           dbg_state;

    logic model_ready = 1'b0;
    logic spur_ready  = 1'b0;
    bit   conv_alive  = 1'b1;
    assign conv_ready = model_ready | spur_ready;

    int checks = 0;
    int errors = 0;

    bcd_conv_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT), .FLUSH(FLUSH)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_flat(bin_flat),
        .done(done), .done_ch(done_ch), .bcd_res(bcd_res), .timeout_err(timeout_err),
        .busy(busy), .conv_en(conv_en), .conv_bin(conv_bin),
        .conv_bcd(conv_bcd), .conv_ready(conv_ready), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural converter (no reset, fixed latency) ----------------
    int          cv_cnt = 0;
    logic [11:0] cv_bin = '0;
    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (conv_en && conv_alive) begin
            cv_bin <= conv_bin;
            cv_cnt <= CONV_LAT - 1;
        end else if (cv_cnt > 0) begin
            cv_cnt <= cv_cnt - 1;
            if (cv_cnt == 1) begin
                model_ready <= 1'b1;
                conv_bcd    <= to_bcd(int'(cv_bin));
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int model_ptr = 0;
    int en_len    = 0;
    always @(posedge clk) begin
        logic [NUM_CH-1:0]    r;
        logic [NUM_CH*12-1:0] b;
        bit                   alive;
        int                   ch;
        logic [11:0]          opnd;
        logic [EW-1:0]        e;
        r = req;
        b = bin_flat;
        alive = conv_alive;
        #1;
        if (rst) begin
            exp_q.delete();
            model_ptr = 0;
            en_len = 0;
        end else begin
            if (conv_en) begin
                en_len++;
                if (en_len == 1) begin
                    ch = -1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch < 0 && r[(model_ptr + i) % NUM_CH]) ch = (model_ptr + i) % NUM_CH;
                    end
                    if (ch < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant_no_req: launch with req=%b", r);
                    end else begin
                        opnd = b[ch*12 +: 12];
                        check("launch_operand", 32'(conv_bin), 32'(opnd));
                        e = {CH_W'(ch), !alive, alive ? to_bcd(int'(opnd)) : 16'h0000};
                        exp_q.push_back(e);
                        model_ptr = (ch + 1) % NUM_CH;
                    end
                end
            end else begin
                if (en_len > 0) check("conv_en_width", en_len, 1);
                en_len = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done ch=%0d expected no done", done_ch);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done_ch", 32'(done_ch), 32'(e[EW-1:17]));
                    check("sb_timeout_err", 32'(timeout_err), 32'(e[16]));
                    check("sb_bcd_res", 32'(bcd_res), 32'(e[15:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_operand(input int ch, input int v);
        bin_flat[ch*12 +: 12] = 12'(v);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_wait: got no done in %0d cycles expected a done", budget);
        cycles = -1;
    endtask

    task automatic wait_en(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (conv_en) return;
        end
        checks++;
        errors++;
        $display("FAIL en_wait: got no conv_en in %0d cycles expected a launch", budget);
        cycles = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_done_ch"}, 32'(done_ch), 0);
        check({tag, "_bcd_res"}, 32'(bcd_res), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_conv_en"}, 32'(conv_en), 0);
        check({tag, "_conv_bin"}, 32'(conv_bin), 0);
        check({tag, "_busy"}, 32'(busy), 1);
    endtask

    typedef struct {
        int          ch;
        int          opnd;
        logic [15:0] exp_bcd;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        int n;
        vec_t vecs[7];
        int rr_ch[5];
        logic [15:0] rr_bcd[5];
        logic [NUM_CH-1:0] dropped;

        vecs[0] = '{1, 0,    16'h0000};
        vecs[1] = '{2, 9,    16'h0009};
        vecs[2] = '{0, 999,  16'h0999};
        vecs[3] = '{2, 10,   16'h0010};
        vecs[4] = '{1, 100,  16'h0100};
        vecs[5] = '{3, 1234, 16'h1234};
        vecs[6] = '{3, 4095, 16'h4095};
        rr_ch   = '{0, 1, 2, 3, 0};
        rr_bcd  = '{16'h0000, 16'h0009, 16'h1234, 16'h0999, 16'h0000};

        rst = 1'b0;
        req = '0;
        bin_flat = '0;
        #1 rst = 1'b1;
        #2 check_reset_outputs("rst");

        // Reset then single request held through reset and FLUSH.
        @(negedge clk);
        set_operand(0, 4095);
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_en(FLUSH + 20, n);
        check("first_grant_after_flush", n, FLUSH + 1);
        wait_done(60, n);
        check("t1_latency_from_en", n, CONV_LAT + 1);
        check("t1_done_ch", 32'(done_ch), 0);
        check("t1_bcd_res", 32'(bcd_res), 32'h4095);
        check("t1_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        req = '0;

        // Vector table: one requester at a time, fixed end-to-end latency.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_operand(vecs[i].ch, vecs[i].opnd);
            req[vecs[i].ch] = 1'b1;
            wait_done(60, n);
            check("vec_latency", n, CONV_LAT + 2);
            check("vec_done_ch", 32'(done_ch), 32'(vecs[i].ch));
            check("vec_bcd_res", 32'(bcd_res), 32'(vecs[i].exp_bcd));
            check("vec_timeout_err", 32'(timeout_err), 0);
            @(negedge clk);
            req = '0;
            @(posedge clk);
            #1 check("vec_idle_busy", 32'(busy), 0);
        end

        // All four channels held high: strict rotation from channel 0.
        @(negedge clk);
        set_operand(0, 0);
        set_operand(1, 9);
        set_operand(2, 1234);
        set_operand(3, 999);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_done(80, n);
            check(k == 0 ? "rr_first_latency" : "rr_period", n, k == 0 ? CONV_LAT + 2 : CONV_LAT + 3);
            check("rr_done_ch", 32'(done_ch), 32'(rr_ch[k]));
            check("rr_bcd_res", 32'(bcd_res), 32'(rr_bcd[k]));
        end
        @(negedge clk);
        req = '0;

        // Fairness: ch1 arrives while ch3 is served; ch1 must beat ch3's repeat.
        @(negedge clk);
        set_operand(3, 77);
        req[3] = 1'b1;
        repeat (10) @(negedge clk);
        set_operand(1, 55);
        req[1] = 1'b1;
        wait_done(60, n);
        check("fair_first_ch", 32'(done_ch), 3);
        wait_done(60, n);
        check("fair_second_ch", 32'(done_ch), 1);
        check("fair_second_bcd", 32'(bcd_res), 32'h0055);
        @(negedge clk);
        req[1] = 1'b0;
        wait_done(60, n);
        check("fair_third_ch", 32'(done_ch), 3);
        @(negedge clk);
        req = '0;

        // Converter that never answers: abort after START plus TIMEOUT wait cycles.
        @(negedge clk);
        conv_alive = 1'b0;
        set_operand(2, 500);
        req[2] = 1'b1;
        wait_en(10, n);
        wait_done(TIMEOUT + 20, n);
        check("tmo_cycles_incl_en", n + 1, TIMEOUT + 2);
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_bcd_res", 32'(bcd_res), 0);
        check("tmo_done_ch", 32'(done_ch), 2);
        @(negedge clk);
        req = '0;
        conv_alive = 1'b1;
        @(negedge clk);
        set_operand(0, 777);
        req[0] = 1'b1;
        wait_en(10, n);
        check("tmo_err_cleared_on_launch", 32'(timeout_err), 0);
        wait_done(60, n);
        check("post_tmo_bcd", 32'(bcd_res), 32'h0777);
        check("post_tmo_err", 32'(timeout_err), 0);
        @(negedge clk);
        req = '0;

        // Spurious conv_ready while IDLE.
        @(negedge clk);
        spur_ready = 1'b1;
        @(negedge clk);
        spur_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("spur_no_done", 32'(done), 0);
            check("spur_stays_idle", 32'(busy), 0);
        end

        // Reset ten cycles into WAIT; the stale converter result lands during FLUSH.
        @(negedge clk);
        set_operand(1, 321);
        req[1] = 1'b1;
        wait_en(10, n);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("midwait_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_en(FLUSH + 20, n);
        check("midwait_first_grant", n, FLUSH + 1);
        wait_done(60, n);
        check("midwait_done_ch", 32'(done_ch), 1);
        check("midwait_bcd_res", 32'(bcd_res), 32'h0321);
        @(negedge clk);
        req = '0;

        // Random traffic against the reference model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            dropped = '0;
            if (done && $urandom_range(0, 3) != 0) begin
                req[done_ch] = 1'b0;
                dropped[done_ch] = 1'b1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!req[c] && !dropped[c] && $urandom_range(0, 15) == 0) begin
                    set_operand(c, int'($urandom_range(0, 4095)));
                    req[c] = 1'b1;
                end
            end
        end
        @(negedge clk);
        req = '0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check("drain_idle", 32'(busy), 0);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
